// File: rtl/gold_miner_pkg.sv
// -----------------------------------------------------------------------------
// gold_miner_pkg
// Shared constants for the gold-miner drawing path: visible frame size,
// colour format and transparent key, sprite type codes, digit sprite
// dimensions and the draw engine state encoding.
// -----------------------------------------------------------------------------
package gold_miner_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int COLOUR_W = 9;

   // 3 bits per channel; magenta-ish key is never plotted
   localparam logic [COLOUR_W-1:0] TRANSPARENT = 9'b111_000_111;

   // Sprite type codes
   localparam logic [4:0] DIGIT_0 = 5'd0;
   localparam logic [4:0] DIGIT_1 = 5'd1;
   localparam logic [4:0] DIGIT_2 = 5'd2;
   localparam logic [4:0] DIGIT_3 = 5'd3;
   localparam logic [4:0] DIGIT_4 = 5'd4;
   localparam logic [4:0] DIGIT_5 = 5'd5;
   localparam logic [4:0] DIGIT_6 = 5'd6;
   localparam logic [4:0] DIGIT_7 = 5'd7;
   localparam logic [4:0] DIGIT_8 = 5'd8;
   localparam logic [4:0] DIGIT_9 = 5'd9;
   localparam logic [4:0] GOLD_M  = 5'd10;
   localparam logic [4:0] GOLD_L  = 5'd11;
   localparam logic [4:0] ROCK_L  = 5'd13;
   localparam logic [4:0] ROCK_M  = 5'd14;

   // Digits ignore object_length/object_height and use a fixed cell
   localparam logic [4:0] DIGIT_W = 5'd6;
   localparam logic [4:0] DIGIT_H = 5'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } engine_state_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// -----------------------------------------------------------------------------
// sprite_scan_counter
// Raster scan of a sprite rectangle: column, row and linear ROM address.
//   clk, resetn          clock, synchronous active-low reset
//   load                 clear counters and capture load_width/load_height
//   load_width/height    rectangle size (1..31 when scanning)
//   inc                  advance one pixel (col first, then row)
//   col, row             current pixel position inside the sprite
//   addr                 row*width+col, kept as a running count
//   last                 current pixel is the bottom-right one
// -----------------------------------------------------------------------------
module sprite_scan_counter (
   input  logic       clk,
   input  logic       resetn,
   input  logic       load,
   input  logic [4:0] load_width,
   input  logic [4:0] load_height,
   input  logic       inc,
   output logic [4:0] col,
   output logic [4:0] row,
   output logic [9:0] addr,
   output logic       last
);

   logic [4:0] width_q;
   logic [4:0] height_q;
   logic       col_end;

   assign col_end = (col == (width_q - 5'd1));
   assign last    = col_end && (row == (height_q - 5'd1));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         width_q  <= 5'd0;
         height_q <= 5'd0;
         col      <= 5'd0;
         row      <= 5'd0;
         addr     <= 10'd0;
      end else if (load) begin
         width_q  <= load_width;
         height_q <= load_height;
         col      <= 5'd0;
         row      <= 5'd0;
         addr     <= 10'd0;
      end else if (inc) begin
         // addr is a running count, so no multiplier is needed
         addr <= addr + 10'd1;
         if (col_end) begin
            col <= 5'd0;
            row <= row + 5'd1;
         end else begin
            col <= col + 5'd1;
         end
      end
   end

endmodule

// File: rtl/draw_object_engine.sv
// -----------------------------------------------------------------------------
// draw_object_engine
// Draws one sprite per command: scans the sprite rectangle, reads the
// external sprite ROM and emits VGA plot writes through a 2-stage pipeline,
// dropping transparent pixels and pixels outside the visible frame.
//   clk, resetn                     clock, synchronous active-low reset
//   start_draw_object               level request from the initiator
//   x_position, y_position          top-left corner of the sprite
//   object_type                     sprite select (0-9 digits, 10/11/13/14)
//   object_length, object_height    size for non-digit types
//   rom_type, rom_addr, rom_data    sprite ROM port (data one cycle late)
//   vga_x, vga_y, vga_colour        registered plot write
//   vga_plot                        plot strobe
//   draw_object_done                completion, held until start drops
//
// Handshake: the initiator raises start_draw_object and holds it with stable
// command fields until draw_object_done is seen. Fields are captured in the
// IDLE cycle where start is high. done stays high while in DONE and the engine
// returns to IDLE on the first cycle start is sampled low there; start
// dropping earlier does not cut the draw short.
// -----------------------------------------------------------------------------
module draw_object_engine
   import gold_miner_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                start_draw_object,
   input  logic [8:0]          x_position,
   input  logic [7:0]          y_position,
   input  logic [4:0]          object_type,
   input  logic [4:0]          object_length,
   input  logic [4:0]          object_height,
   output logic [4:0]          rom_type,
   output logic [9:0]          rom_addr,
   input  logic [COLOUR_W-1:0] rom_data,
   output logic [8:0]          vga_x,
   output logic [7:0]          vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   output logic                draw_object_done
);

   localparam logic [9:0] X_LIMIT = 10'(SCREEN_W);
   localparam logic [8:0] Y_LIMIT = 9'(SCREEN_H);

   engine_state_t state_q, state_d;

   logic [8:0] x_q;
   logic [7:0] y_q;
   logic       flush_q;

   logic [4:0] ld_width;
   logic [4:0] ld_height;
   logic       load;
   logic       scan_inc;
   logic [4:0] col;
   logic [4:0] row;
   logic [9:0] addr;
   logic       last;

   // Stage 1: screen coordinates one bit wider so off-frame pixels
   // cannot wrap back into view.
   logic       s1_valid;
   logic [9:0] s1_x;
   logic [8:0] s1_y;

   assign ld_width  = (object_type <= DIGIT_9) ? DIGIT_W : object_length;
   assign ld_height = (object_type <= DIGIT_9) ? DIGIT_H : object_height;
   assign rom_addr  = addr;

   sprite_scan_counter u_scan (
      .clk         (clk),
      .resetn      (resetn),
      .load        (load),
      .load_width  (ld_width),
      .load_height (ld_height),
      .inc         (scan_inc),
      .col         (col),
      .row         (row),
      .addr        (addr),
      .last        (last)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      load             = 1'b0;
      scan_inc         = 1'b0;
      draw_object_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_draw_object) begin
               load = 1'b1;
               if (ld_width == 5'd0 || ld_height == 5'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            scan_inc = 1'b1;
            if (last) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // second FLUSH cycle: last pixel is in stage 2 output now
            if (flush_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            draw_object_done = 1'b1;
            if (!start_draw_object) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Command latch and flush cycle marker
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_q      <= 9'd0;
         y_q      <= 8'd0;
         rom_type <= 5'd0;
         flush_q  <= 1'b0;
      end else begin
         if (load) begin
            x_q      <= x_position;
            y_q      <= y_position;
            rom_type <= object_type;
         end
         flush_q <= (state_q == ST_FLUSH);
      end
   end

   // Stage 1 aligns coordinates with rom_data, which arrives a cycle after
   // the address; stage 2 qualifies and registers the write.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid   <= 1'b0;
         s1_x       <= 10'd0;
         s1_y       <= 9'd0;
         vga_x      <= 9'd0;
         vga_y      <= 8'd0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         s1_valid   <= (state_q == ST_RUN);
         s1_x       <= {1'b0, x_q} + {5'd0, col};
         s1_y       <= {1'b0, y_q} + {4'd0, row};
         vga_x      <= s1_x[8:0];
         vga_y      <= s1_y[7:0];
         vga_colour <= rom_data;
         vga_plot   <= s1_valid && (rom_data != TRANSPARENT) &&
                       (s1_x < X_LIMIT) && (s1_y < Y_LIMIT);
      end
   end

endmodule
